// File: rtl/mem_align_unit.sv
// Byte-addressed core requests mapped onto an aligned memory bus, with lane steering and load extension.
// Define MEM_ALIGN_SPLIT_EN to run boundary-crossing accesses as two beats; otherwise they are rejected.
module mem_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic                    i_req_we,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD0 = 3'd1,
    RD0  = 3'd2,
    DONE = 3'd3
`ifdef MEM_ALIGN_SPLIT_EN
    ,
    CMD1 = 3'd4,
    RD1  = 3'd5
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
`ifdef MEM_ALIGN_SPLIT_EN
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                    split_s;
`endif
  logic [OFFW-1:0]         off_s;
  logic                    bad_s;
  logic [ADDR_WIDTH-1:0]   base_s;
  logic [DATA_WIDTH-1:0]   ld_raw_s;
  logic [DATA_WIDTH-1:0]   ld_ext_s;
  logic                    sign_s;
  logic [7:0]              nbits_s;

  function automatic logic crosses(input logic [OFFW-1:0] off, input logic [1:0] size);
    logic [4:0] sum;
    sum = 5'(off) + (5'd1 << size);
    return (sum > 5'(NB));
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = NB'(8'h01);
      2'd1:    lane_mask = NB'(8'h03);
      2'd2:    lane_mask = NB'(8'h0F);
      default: lane_mask = '1;
    endcase
  endfunction

  assign off_s  = addr_q[OFFW-1:0];
  assign base_s = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

`ifdef MEM_ALIGN_SPLIT_EN
  assign split_s  = crosses(off_s, size_q);
  assign bad_s    = (i_req_size > 2'(OFFW));
  assign ld_raw_s = DATA_WIDTH'({rdata1_q, rdata0_q} >> {off_s, 3'b000});
`else
  // Without split support a crossing request is refused before any bus activity.
  assign bad_s    = (i_req_size > 2'(OFFW)) || crosses(i_req_addr[OFFW-1:0], i_req_size);
  assign ld_raw_s = rdata0_q >> {off_s, 3'b000};
`endif

  // State and request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
`ifdef MEM_ALIGN_SPLIT_EN
      rdata1_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
`ifdef MEM_ALIGN_SPLIT_EN
      rdata1_q <= rdata1_d;
`endif
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
`ifdef MEM_ALIGN_SPLIT_EN
    rdata1_d = rdata1_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d   = i_req_addr;
          we_d     = i_req_we;
          size_d   = i_req_size;
          uns_d    = i_req_unsigned;
          wdata_d  = i_req_wdata;
          err_d    = bad_s;
          rdata0_d = '0;
`ifdef MEM_ALIGN_SPLIT_EN
          rdata1_d = '0;
`endif
          state_d  = bad_s ? DONE : CMD0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD0: begin
        if (!i_mem_ready) begin
          state_d = CMD0;
        end else if (!we_q) begin
          state_d = RD0;
        end else begin
`ifdef MEM_ALIGN_SPLIT_EN
          state_d = split_s ? CMD1 : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      RD0: begin
        if (i_mem_rvalid) begin
          rdata0_d = i_mem_rdata;
`ifdef MEM_ALIGN_SPLIT_EN
          state_d  = split_s ? CMD1 : DONE;
`else
          state_d  = DONE;
`endif
        end else begin
          state_d = RD0;
        end
      end
`ifdef MEM_ALIGN_SPLIT_EN
      CMD1: begin
        if (i_mem_ready) begin
          state_d = we_q ? DONE : RD1;
        end else begin
          state_d = CMD1;
        end
      end
      RD1: begin
        if (i_mem_rvalid) begin
          rdata1_d = i_mem_rdata;
          state_d  = DONE;
        end else begin
          state_d = RD1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extension: bytes beyond the access length take the sign bit unless zero-extending.
  always_comb begin
    ld_ext_s = '0;
    nbits_s  = 8'd8 << size_q;
    case (size_q)
      2'd0:    sign_s = ld_raw_s[7];
      2'd1:    sign_s = ld_raw_s[15];
      2'd2:    sign_s = ld_raw_s[31];
      default: sign_s = 1'b0;
    endcase
    if (uns_q) begin
      sign_s = 1'b0;
    end else begin
      sign_s = sign_s;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ld_ext_s[i] = (8'(i) < nbits_s) ? ld_raw_s[i] : sign_s;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_mem_we    = we_q;
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_wstrb = '0;
    o_mem_wdata = '0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = '0;
    case (state_q)
      CMD0: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = base_s;
        o_mem_wdata = wdata_q << {off_s, 3'b000};
        o_mem_wstrb = we_q ? (lane_mask(size_q) << off_s) : '0;
      end
`ifdef MEM_ALIGN_SPLIT_EN
      CMD1: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = base_s + ADDR_WIDTH'(NB);
        o_mem_wdata = wdata_q >> {((OFFW+1)'(NB) - {1'b0, off_s}), 3'b000};
        o_mem_wstrb = we_q ? (lane_mask(size_q) >> ((OFFW+1)'(NB) - {1'b0, off_s})) : '0;
      end
`endif
      DONE: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (we_q || err_q) ? '0 : ld_ext_s;
      end
      default: begin
        o_mem_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit at DATA_WIDTH=32; split cases follow MEM_ALIGN_SPLIT_EN.
module tb_mem_align_unit;
  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_wdata(req_wdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request in IDLE for a single edge, then withdraw it.
  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] wd);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
    req_unsigned = un; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Complete an aligned single-beat load already sitting in CMD0 with ready high.
  task automatic load_one(input string tag, input logic [31:0] rd, input logic [31:0] exp);
    step();
    mem_rvalid = 1'b1; mem_rdata = rd;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp));
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;

    step();
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_addr", 64'(mem_addr), 64'd0);
    chk("post_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("post_rst_wstrb", 64'(mem_wstrb), 64'd0);
    chk("post_rst_rsp", 64'({rsp_err, rsp_rdata}), 64'd0);

    // Byte store at lane 3 with a 3-cycle stall; a request arriving mid-flight must be ignored.
    req_valid = 1'b1; req_addr = 32'h1003; req_we = 1'b1; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0000_00AB;
    step();
    req_addr = 32'h0000_FFFF; req_wdata = 32'h5555_5555;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3) ? 1'b1 : 1'b0;
      chk("stb_valid", 64'(mem_valid), 64'd1);
      chk("stb_ready_low", 64'(req_ready), 64'd0);
      chk("stb_addr", 64'(mem_addr), 64'h1000);
      chk("stb_wstrb", 64'(mem_wstrb), 64'h8);
      chk("stb_wdata", 64'(mem_wdata), 64'hAB00_0000);
      step();
    end
    req_valid = 1'b0;
    chk("stb_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("stb_rsp_err", 64'(rsp_err), 64'd0);
    chk("stb_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("stb_done_wstrb", 64'(mem_wstrb), 64'd0);
    step();
    chk("stb_pulse_end", 64'(rsp_valid), 64'd0);
    chk("stb_idle_ready", 64'(req_ready), 64'd1);

    // Aligned word store: response two cycles after acceptance.
    issue(32'h0000_0040, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF);
    chk("stw_addr", 64'(mem_addr), 64'h40);
    chk("stw_wstrb", 64'(mem_wstrb), 64'hF);
    chk("stw_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("stw_we", 64'(mem_we), 64'd1);
    step();
    chk("stw_rsp_valid", 64'(rsp_valid), 64'd1);
    step();

    // Loads of 0x8001_1234 at various offsets/sizes.
    issue(32'h0000_2002, 1'b0, 2'd1, 1'b0, 32'h0);
    chk("ldh_addr", 64'(mem_addr), 64'h2000);
    chk("ldh_wstrb", 64'(mem_wstrb), 64'd0);
    chk("ldh_we", 64'(mem_we), 64'd0);
    load_one("ldh_s", 32'h8001_1234, 32'hFFFF_8001);

    issue(32'h0000_2002, 1'b0, 2'd1, 1'b1, 32'h0);
    step();
    step();
    chk("ldh_u_wait", 64'(rsp_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    step();
    mem_rvalid = 1'b0;
    chk("ldh_u_rdata", 64'(rsp_rdata), 64'h0000_8001);
    step();

    issue(32'h0000_2003, 1'b0, 2'd0, 1'b0, 32'h0);
    load_one("ldb_s", 32'h8001_1234, 32'hFFFF_FF80);
    issue(32'h0000_2001, 1'b0, 2'd0, 1'b0, 32'h0);
    load_one("ldb_pos", 32'h8001_1234, 32'h0000_0012);
    issue(32'h0000_2000, 1'b0, 2'd2, 1'b0, 32'h0);
    load_one("ldw", 32'h8001_1234, 32'h8001_1234);

    // Doubleword on a 32-bit bus is rejected without a bus command.
    issue(32'h0000_2000, 1'b0, 2'd3, 1'b0, 32'h0);
    chk("sz_err_memv", 64'(mem_valid), 64'd0);
    chk("sz_err_rsp", 64'({rsp_valid, rsp_err}), 64'h3);
    chk("sz_err_rdata", 64'(rsp_rdata), 64'd0);
    step();

    // Boundary-crossing word store at 0x3003.
    issue(32'h0000_3003, 1'b1, 2'd2, 1'b0, 32'h1122_3344);
`ifdef MEM_ALIGN_SPLIT_EN
    chk("sp_b0_addr", 64'(mem_addr), 64'h3000);
    chk("sp_b0_wstrb", 64'(mem_wstrb), 64'h8);
    chk("sp_b0_wdata", 64'(mem_wdata), 64'h4400_0000);
    step();
    chk("sp_b1_addr", 64'(mem_addr), 64'h3004);
    chk("sp_b1_wstrb", 64'(mem_wstrb), 64'h7);
    chk("sp_b1_wdata", 64'(mem_wdata), 64'h0011_2233);
    step();
    chk("sp_rsp", 64'({rsp_valid, rsp_err}), 64'h2);
    step();
    issue(32'h0000_3003, 1'b0, 2'd1, 1'b0, 32'h0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hAA00_0000;
    step();
    mem_rvalid = 1'b0;
    chk("spl_b1_addr", 64'(mem_addr), 64'h3004);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00BB;
    step();
    mem_rvalid = 1'b0;
    chk("spl_rdata", 64'(rsp_rdata), 64'hFFFF_BBAA);
    step();
`else
    chk("nosp_memv", 64'(mem_valid), 64'd0);
    chk("nosp_rsp", 64'({rsp_valid, rsp_err}), 64'h3);
    step();
`endif

    // Reset while waiting for read data; a late rvalid must not produce a response.
    issue(32'h0000_0050, 1'b0, 2'd2, 1'b0, 32'h0);
    step();
    chk("rd0_ready_low", 64'(req_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    chk("rr_ready", 64'(req_ready), 64'd1);
    chk("rr_rsp", 64'(rsp_valid), 64'd0);
    step();
    mem_rvalid = 1'b0;
    chk("rr_late_rsp", 64'(rsp_valid), 64'd0);
    chk("rr_late_ready", 64'(req_ready), 64'd1);
    chk("rr_late_memv", 64'(mem_valid), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
